lut_ram_loader: RTL and testbench

//   Writable counterpart of the norm-LUT ROM: accepts a valid/ready word stream and

---
 rtl/lut_ram_loader.sv | 163 ++++++++++++++++
 tb/tb_lut_ram_loader.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lut_ram_loader.sv
// lut_ram_loader: run-time reloadable normalisation LUT.
// A valid/ready word stream is written sequentially into the LUT memory.
// Reads go through a ROM-compatible registered port (address/enable/data_out).
// Optional feature macro: LUT_LOAD_CHECKSUM_EN adds a running checksum output.
//
// Handshake: a word transfers on a rising edge where wr_valid && wr_ready are
// both high. wr_ready is a register driven only by the FSM state, so it never
// depends combinationally on wr_valid. Dropping wr_valid stalls the load
// indefinitely; words offered while wr_ready is low are discarded.
module lut_ram_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6,
  parameter     TYPE       = "DISTRIBUTED"
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_start,
  input  logic [ADDR_WIDTH:0]   load_count,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic                  load_busy,
  output logic                  load_done,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  enable,
  output logic [DATA_WIDTH-1:0] data_out,
`ifdef LUT_LOAD_CHECKSUM_EN
  output logic [DATA_WIDTH-1:0] checksum,
`endif
  output logic [1:0]            fsm_state_o
);

  localparam int                 DEPTH     = 1 << ADDR_WIDTH;
  localparam int                 CNT_W     = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0]   DEPTH_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic                    wr_ready_q, wr_ready_d;
  logic                    load_busy_q, load_busy_d;
  logic                    load_done_q, load_done_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [CNT_W-1:0]        remaining_q, remaining_d;
  logic [CNT_W-1:0]        count_clamped;
  logic [DATA_WIDTH-1:0]   data_out_q;
  logic                    accept;

  (* ram_style = TYPE *) logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  assign accept        = wr_valid & wr_ready_q;
  // A count of zero, or anything larger than the table, means a full reload.
  assign count_clamped = (load_count == '0 || load_count > DEPTH_CNT) ? DEPTH_CNT : load_count;

  // State and registered handshake/status flags; reset returns to IDLE at once.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wr_ready_q  <= 1'b0;
      load_busy_q <= 1'b0;
      load_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ready_q  <= wr_ready_d;
      load_busy_q <= load_busy_d;
      load_done_q <= load_done_d;
    end
  end

  // Next-state logic: load_start only matters in IDLE; last accept ends LOAD.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (load_start) state_d = S_LOAD;
      S_LOAD:  if (accept && remaining_q == CNT_W'(1)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the next state so the registered flags track state_q.
  always_comb begin
    wr_ready_d  = (state_d == S_LOAD);
    load_busy_d = (state_d == S_LOAD);
    load_done_d = (state_d == S_DONE);
  end

  // Write pointer and words-left counter for the current load session.
  always_comb begin
    wr_addr_d   = wr_addr_q;
    remaining_d = remaining_q;
    if (state_q == S_IDLE && load_start) begin
      wr_addr_d   = '0;
      remaining_d = count_clamped;
    end else if (accept) begin
      wr_addr_d   = wr_addr_q + ADDR_WIDTH'(1);
      remaining_d = remaining_q - CNT_W'(1);
    end
  end

  // Datapath registers for the load session.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_addr_q   <= '0;
      remaining_q <= '0;
    end else begin
      wr_addr_q   <= wr_addr_d;
      remaining_q <= remaining_d;
    end
  end

  // LUT write; contents survive reset, and reset blocks a write in its cycle.
  always_ff @(posedge clk) begin
    if (!reset && accept) begin
      mem_q[wr_addr_q] <= wr_data;
    end
  end

  // Registered read, read-first on a same-address write, holds when disabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out_q <= '0;
    end else if (enable) begin
      data_out_q <= mem_q[address];
    end
  end

`ifdef LUT_LOAD_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] checksum_q, checksum_d;

  // Running sum of accepted words, restarted when a load session opens.
  always_comb begin
    checksum_d = checksum_q;
    if (state_q == S_IDLE && load_start) begin
      checksum_d = '0;
    end else if (accept) begin
      checksum_d = checksum_q + wr_data;
    end
  end

  // Checksum register; holds after DONE until the next session or reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`endif

  assign wr_ready    = wr_ready_q;
  assign load_busy   = load_busy_q;
  assign load_done   = load_done_q;
  assign data_out    = data_out_q;
  assign fsm_state_o = state_q;

endmodule

// File: tb/tb_lut_ram_loader.sv
// Testbench for lut_ram_loader: directed scenarios plus a randomized phase,
// all checked every cycle against a behavioural model of the LUT loader.
`timescale 1ns/1ps
module tb_lut_ram_loader;
  localparam int DW    = 16;
  localparam int AW    = 6;
  localparam int DEPTH = 1 << AW;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          reset;
  logic          load_start;
  logic [AW:0]   load_count;
  logic [DW-1:0] wr_data;
  logic          wr_valid;
  logic          wr_ready;
  logic          load_busy;
  logic          load_done;
  logic [AW-1:0] address;
  logic          enable;
  logic [DW-1:0] data_out;
  logic [1:0]    fsm_state;
`ifdef LUT_LOAD_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  always #5 clk = ~clk;

  lut_ram_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TYPE("DISTRIBUTED")) dut (
    .clk        (clk),
    .reset      (reset),
    .load_start (load_start),
    .load_count (load_count),
    .wr_data    (wr_data),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .load_busy  (load_busy),
    .load_done  (load_done),
    .address    (address),
    .enable     (enable),
    .data_out   (data_out),
`ifdef LUT_LOAD_CHECKSUM_EN
    .checksum   (checksum),
`endif
    .fsm_state_o(fsm_state)
  );

  // ---------------- counters and check helper ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h time=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A load session is "words still owed"; the done pulse is one cycle after
  // the owed count reaches zero. The LUT is an array plus a known-bit.
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_known [DEPTH];
  int            m_left = 0;
  int            m_addr = 0;
  bit            m_done = 1'b0;
  logic [DW-1:0] m_data = '0;
  bit            m_data_known = 1'b0;
  logic [DW-1:0] m_sum = '0;
  bit            model_on = 1'b0;

  initial begin
    for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
  end

  always @(posedge clk) begin
    if (reset) begin
      m_left       = 0;
      m_addr       = 0;
      m_done       = 1'b0;
      m_data       = '0;
      m_data_known = 1'b1;
      m_sum        = '0;
      model_on     = 1'b1;
    end else begin
      // Reads see the table as it was before this edge's write.
      if (enable) begin
        m_data       = m_mem[address];
        m_data_known = m_known[address];
      end
      if (m_done) begin
        m_done = 1'b0;
      end else if (m_left > 0) begin
        if (wr_valid) begin
          m_mem[m_addr]   = wr_data;
          m_known[m_addr] = 1'b1;
          m_addr          = (m_addr + 1) % DEPTH;
          m_sum           = m_sum + wr_data;
          m_left          = m_left - 1;
          if (m_left == 0) m_done = 1'b1;
        end
      end else if (load_start) begin
        m_left = (load_count == 0 || int'(load_count) > DEPTH) ? DEPTH : int'(load_count);
        m_addr = 0;
        m_sum  = '0;
      end
    end
  end

  // Compare process: every cycle once the model has seen a reset.
  always @(negedge clk) begin
    if (model_on) begin
      check("wr_ready", 32'(wr_ready), 32'(m_left > 0));
      check("load_busy", 32'(load_busy), 32'(m_left > 0));
      check("load_done", 32'(load_done), 32'(m_done));
      if (m_data_known) check("data_out", 32'(data_out), 32'(m_data));
`ifdef LUT_LOAD_CHECKSUM_EN
      check("checksum", 32'(checksum), 32'(m_sum));
`endif
    end
  end

  // Independent event counters taken from the DUT's own handshake.
  int dut_accepts = 0;
  int dut_dones   = 0;
  always @(posedge clk) if (!reset && wr_valid && wr_ready) dut_accepts++;
  always @(negedge clk) if (load_done) dut_dones++;

  // ---------------- driver tasks ----------------
  logic [DW-1:0] words [DEPTH];
  logic [DW-1:0] exp_q [$];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic load_words(input int count_in, input int n, input bit gaps, input bit hold_start);
    load_start = 1'b1;
    load_count = (AW+1)'(count_in);
    tick();
    load_start = hold_start;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        wr_valid = 1'b0;
        wr_data  = DW'($urandom);
        tick();
      end
      wr_valid = 1'b1;
      wr_data  = words[i];
      tick();
    end
    wr_valid   = 1'b0;
    load_start = 1'b0;
    check("done_after_last_word", 32'(load_done), 32'd1);
    tick();
    check("done_single_cycle", 32'(load_done), 32'd0);
  endtask

  task automatic read_chk(input int a, input logic [DW-1:0] exp, input string name);
    address = AW'(a);
    enable  = 1'b1;
    tick();
    check(name, 32'(data_out), 32'(exp));
    enable  = 1'b0;
  endtask

  task automatic set_base_words();
    words[0] = 16'h1111; words[1] = 16'h2222;
    words[2] = 16'h3333; words[3] = 16'h4444;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int acc0, done0;
    reset = 1'b1; load_start = 1'b0; load_count = '0; wr_data = '0;
    wr_valid = 1'b0; address = AW'(5); enable = 1'b1;

    // Reset state with a read pending
    tick();
    check("reset_data_out", 32'(data_out), 32'h0);
    check("reset_wr_ready", 32'(wr_ready), 32'h0);
    check("reset_load_busy", 32'(load_busy), 32'h0);
    tick();
    reset = 1'b0; enable = 1'b0;
    tick();

    // Four-word back-to-back load
    set_base_words();
    for (int i = 0; i < 4; i++) exp_q.push_back(words[i]);
    load_words(4, 4, 1'b0, 1'b0);
`ifdef LUT_LOAD_CHECKSUM_EN
    check("checksum_4w", 32'(checksum), 32'hAAAA);
`endif

    // Words offered in IDLE are dropped
    wr_valid = 1'b1; wr_data = 16'hDEAD;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_wr_ready", 32'(wr_ready), 32'h0);
    end
    wr_valid = 1'b0;
    for (int i = 0; i < 4; i++) read_chk(i, exp_q.pop_front(), "readback_4w");

    // Full-depth load with wr_valid toggling
    for (int i = 0; i < DEPTH; i++) words[i] = DW'(16'h0100 + i);
    acc0 = dut_accepts; done0 = dut_dones;
    load_words(0, DEPTH, 1'b1, 1'b0);
    check("full_accepts", 32'(dut_accepts - acc0), 32'd64);
    check("full_dones", 32'(dut_dones - done0), 32'd1);
    read_chk(63, 16'h013F, "full_mem63");
    read_chk(0, 16'h0100, "full_mem0");

    // load_start held through LOAD does not restart the count
    for (int i = 0; i < 4; i++) words[i] = DW'(16'hA000 + i);
    load_words(4, 4, 1'b0, 1'b1);

    // Reset mid-load
    set_base_words();
    load_words(4, 4, 1'b0, 1'b0);
    load_start = 1'b1; load_count = 7'd4;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wr_valid = 1'b1; wr_data = DW'(16'h5000 + i);
      tick();
    end
    wr_valid = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midreset_busy", 32'(load_busy), 32'h0);
    check("midreset_ready", 32'(wr_ready), 32'h0);
    read_chk(0, 16'h5000, "midreset_mem0");
    read_chk(1, 16'h5001, "midreset_mem1");
    read_chk(2, 16'h3333, "midreset_mem2");
    read_chk(3, 16'h4444, "midreset_mem3");
    for (int i = 0; i < 4; i++) words[i] = DW'(16'h6000 + i);
    load_words(4, 4, 1'b0, 1'b0);

    // Read/write collision on address 2
    set_base_words();
    load_words(4, 4, 1'b0, 1'b0);
    load_start = 1'b1; load_count = 7'd4;
    tick();
    load_start = 1'b0;
    wr_valid = 1'b1; wr_data = 16'h0BB0; tick();
    wr_data = 16'h0BB1; tick();
    wr_data = 16'h7777; address = AW'(2); enable = 1'b1;
    tick();
    check("collision_old", 32'(data_out), 32'h3333);
    wr_data = 16'h0BB3;
    tick();
    check("collision_new", 32'(data_out), 32'h7777);
    check("collision_done", 32'(load_done), 32'd1);
    wr_valid = 1'b0; enable = 1'b0;
    for (int i = 0; i < 2; i++) begin
      address = AW'($urandom);
      tick();
      check("enable_low_hold", 32'(data_out), 32'h7777);
    end

    // Randomized phase
    for (int c = 0; c < 3000; c++) begin
      reset      = ($urandom_range(0, 299) == 0);
      load_start = ($urandom_range(0, 15) == 0);
      load_count = ($urandom_range(0, 3) == 0) ? (AW+1)'($urandom_range(0, 127))
                                               : (AW+1)'($urandom_range(1, 8));
      wr_valid   = 1'($urandom_range(0, 1));
      wr_data    = DW'($urandom);
      address    = AW'($urandom);
      enable     = 1'($urandom_range(0, 1));
      tick();
    end
    reset = 1'b0; load_start = 1'b0; wr_valid = 1'b0; enable = 1'b0;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
